// File: rtl/inst_fetch_if.sv
// -----------------------------------------------------------------------------
// inst_fetch_if
//   Bundles every bus signal of the instruction fetch stage: the instruction
//   memory request/response channel, the redirect input from execute and the
//   instruction output toward decode. Signal names keep the fetch stage's
//   direction suffix (_o driven by fetch, _i driven by its environment).
//
//   Handshake rules for both valid/ready channels (imem request, decode
//   output): a transfer happens on a rising clock edge where valid and ready
//   are both 1; valid never depends combinationally on ready of the same
//   channel except imem_req_valid_o, which looks at inst_ready_i to allow a
//   fetch while the output buffer is draining. The imem response channel is
//   valid-only and cannot be stalled.
//
// Modports
//   master : fetch stage view
//   slave  : environment view (memory + decode + execute)
// -----------------------------------------------------------------------------
interface inst_fetch_if;
   logic        imem_req_valid_o;
   logic        imem_req_ready_i;
   logic [31:0] imem_req_addr_o;
   logic        imem_rsp_valid_i;
   logic [31:0] imem_rsp_data_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        inst_valid_o;
   logic        inst_ready_i;
   logic [31:0] inst_o;
   logic [31:0] pc_o;

   modport master (
      output imem_req_valid_o, imem_req_addr_o, inst_valid_o, inst_o, pc_o,
      input  imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i,
             redirect_i, redirect_pc_i, inst_ready_i
   );

   modport slave (
      input  imem_req_valid_o, imem_req_addr_o, inst_valid_o, inst_o, pc_o,
      output imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i,
             redirect_i, redirect_pc_i, inst_ready_i
   );
endinterface

// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
//   Instruction fetch stage. Owns the PC, issues one word-aligned read at a
//   time to instruction memory and hands each returned word (with its PC) to
//   decode through a one-entry valid/ready buffer. A redirect from execute
//   reloads the PC, flushes the buffer and marks any outstanding fetch as
//   stale (kill) so its response is discarded.
//
// Ports
//   clk_i       : clock, rising edge
//   rst_n_i     : asynchronous active-low reset
//   bus         : inst_fetch_if.master (imem request/response, redirect,
//                 instruction output to decode)
//   o_dbg_state : current FSM state (0 = REQ, 1 = WAIT)
// -----------------------------------------------------------------------------
module inst_fetch #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
   input  logic         clk_i,
   input  logic         rst_n_i,
   inst_fetch_if.master bus,
   output logic [0:0]   o_dbg_state
);

   localparam logic [0:0] S_REQ  = 1'b0;
   localparam logic [0:0] S_WAIT = 1'b1;

   logic [0:0]  r_state;
   logic [31:0] r_pc;
   logic        r_kill;
   logic        r_inst_valid;
   logic [31:0] r_inst;
   logic [31:0] r_pc_o;

   logic        w_req_valid;
   logic        w_req_hs;
   logic        w_load;

   // A request only goes out when the output buffer is empty or being drained
   // this cycle, so the response is guaranteed to find the buffer free.
   // The reset term keeps the request low while rst_n_i is asserted even
   // though inst_ready_i may be high.
   assign w_req_valid = rst_n_i && (r_state == S_REQ) &&
                        (!r_inst_valid || bus.inst_ready_i);
   assign w_req_hs    = w_req_valid && bus.imem_req_ready_i;

   // A response is kept only if its fetch was not killed and no redirect
   // arrives in the same cycle.
   assign w_load = (r_state == S_WAIT) && bus.imem_rsp_valid_i &&
                   !r_kill && !bus.redirect_i;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state      <= S_REQ;
         r_pc         <= RESET_PC;
         r_kill       <= 1'b0;
         r_inst_valid <= 1'b0;
         r_inst       <= 32'h0;
         r_pc_o       <= 32'h0;
      end else begin
         // Output buffer: redirect flushes regardless of inst_ready_i.
         if (bus.redirect_i) begin
            r_inst_valid <= 1'b0;
         end else if (w_load) begin
            r_inst_valid <= 1'b1;
            r_inst       <= bus.imem_rsp_data_i;
            r_pc_o       <= r_pc;
         end else if (bus.inst_ready_i) begin
            r_inst_valid <= 1'b0;
         end

         // PC: redirect wins; increment wraps naturally at 2^32.
         if (bus.redirect_i) begin
            r_pc <= {bus.redirect_pc_i[31:2], 2'b00};
         end else if (w_load) begin
            r_pc <= r_pc + 32'd4;
         end

         case (r_state)
            S_REQ: begin
               if (w_req_hs) begin
                  r_state <= S_WAIT;
                  // Request to the old PC is now in flight; drop its response.
                  if (bus.redirect_i) r_kill <= 1'b1;
               end
            end
            S_WAIT: begin
               if (bus.imem_rsp_valid_i) begin
                  r_state <= S_REQ;
                  r_kill  <= 1'b0;
               end else if (bus.redirect_i) begin
                  r_kill  <= 1'b1;
               end
            end
            default: r_state <= S_REQ;
         endcase
      end
   end

   assign bus.imem_req_valid_o = w_req_valid;
   assign bus.imem_req_addr_o  = r_pc;
   assign bus.inst_valid_o     = r_inst_valid;
   assign bus.inst_o           = r_inst;
   assign bus.pc_o             = r_pc_o;
   assign o_dbg_state          = r_state;

endmodule

// File: tb/tb_inst_fetch.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch
//   Directed bench for inst_fetch. Inputs are driven 1-2 ns after the rising
//   edge; the monitor samples on the falling edge. The memory model returns
//   ~addr as the instruction word, so every expected word below is the bitwise
//   inverse of its PC, written out by hand.
// -----------------------------------------------------------------------------
module tb_inst_fetch;

   logic       clk;
   logic       rst_n;
   logic [0:0] dbg_state;

   inst_fetch_if bus ();

   inst_fetch #(.RESET_PC(32'h8000_0000)) dut (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .bus         (bus),
      .o_dbg_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   logic [63:0] exp_q[$];       // {pc, inst} expected at decode handshake
   logic [31:0] exp_addr_q[$];  // expected request addresses in order
   int          hs_cyc[$];      // cycle stamps of request handshakes
   int          checks = 0;
   int          errors = 0;
   int          cyc    = 0;

   // memory model state
   int          mem_budget = 0;  // requests memory will still accept
   int          mem_k      = 1;  // response latency in cycles
   int          mem_cnt    = 0;
   logic [31:0] mem_addr   = 32'h0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL timeout_%s actual=expired required=event", name);
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_drain(input int max_cyc);
      int n = 0;
      while ((exp_q.size() != 0 || exp_addr_q.size() != 0) && n < max_cyc) begin
         step();
         n++;
      end
      if (exp_q.size() != 0 || exp_addr_q.size() != 0) begin
         timeout("drain");
         exp_q.delete();
         exp_addr_q.delete();
      end
   endtask

   task automatic wait_inst_valid(input int max_cyc);
      int n = 0;
      while (bus.inst_valid_o !== 1'b1 && n < max_cyc) begin
         step();
         n++;
      end
      if (bus.inst_valid_o !== 1'b1) timeout("inst_valid");
   endtask

   task automatic wait_state(input logic [0:0] st, input int max_cyc);
      int n = 0;
      while (dbg_state !== st && n < max_cyc) begin
         step();
         n++;
      end
      if (dbg_state !== st) timeout("state");
   endtask

   task automatic wait_rsp(input int max_cyc);
      int n = 0;
      while (bus.imem_rsp_valid_i !== 1'b1 && n < max_cyc) begin
         step();
         n++;
      end
      if (bus.imem_rsp_valid_i !== 1'b1) timeout("rsp");
   endtask

   // ---------------- memory responder (drives at posedge + 1) ----------------
   initial begin
      bus.imem_req_ready_i = 1'b0;
      bus.imem_rsp_valid_i = 1'b0;
      bus.imem_rsp_data_i  = 32'h0;
      forever begin
         @(posedge clk);
         #1;
         bus.imem_rsp_valid_i = 1'b0;
         if (!rst_n) begin
            mem_cnt = 0;
         end else if (mem_cnt > 0) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
               bus.imem_rsp_valid_i = 1'b1;
               bus.imem_rsp_data_i  = ~mem_addr;
            end
         end
         bus.imem_req_ready_i = (mem_budget > 0);
      end
   end

   // ---------------- monitor (samples on negedge) ----------------
   initial begin
      logic [63:0] e;
      logic [31:0] a;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst_n && bus.imem_req_valid_o && bus.imem_req_ready_i) begin
            hs_cyc.push_back(cyc);
            mem_cnt  = mem_k;
            mem_addr = bus.imem_req_addr_o;
            mem_budget--;
            if (exp_addr_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_req actual addr=%h required none", bus.imem_req_addr_o);
            end else begin
               a = exp_addr_q.pop_front();
               chk("req_addr", bus.imem_req_addr_o, a);
            end
         end
         if (rst_n && bus.inst_valid_o && bus.inst_ready_i) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_inst actual pc=%h inst=%h required none",
                        bus.pc_o, bus.inst_o);
            end else begin
               e = exp_q.pop_front();
               chk("inst_pc", bus.pc_o, e[63:32]);
               chk("inst_word", bus.inst_o, e[31:0]);
            end
         end
      end
   end

   // ---------------- directed stimulus ----------------
   initial begin
      rst_n             = 1'b0;
      bus.redirect_i    = 1'b0;
      bus.redirect_pc_i = 32'h0;
      bus.inst_ready_i  = 1'b1;
      mem_budget        = 3;
      mem_k             = 1;
      repeat (3) step();

      // Reset: request gated off even with memory and decode ready.
      chk("rst_req_valid", {31'h0, bus.imem_req_valid_o}, 32'h0);
      chk("rst_inst_valid", {31'h0, bus.inst_valid_o}, 32'h0);
      chk("rst_inst", bus.inst_o, 32'h0);
      chk("rst_pc_o", bus.pc_o, 32'h0);
      chk("rst_state", {31'h0, dbg_state}, 32'h0);
      chk("rst_req_addr", bus.imem_req_addr_o, 32'h8000_0000);

      // Streaming, k=1, decode always ready: one fetch per 2 cycles.
      exp_addr_q.push_back(32'h8000_0000);
      exp_addr_q.push_back(32'h8000_0004);
      exp_addr_q.push_back(32'h8000_0008);
      exp_q.push_back({32'h8000_0000, 32'h7FFF_FFFF});
      exp_q.push_back({32'h8000_0004, 32'h7FFF_FFFB});
      exp_q.push_back({32'h8000_0008, 32'h7FFF_FFF7});
      hs_cyc.delete();
      rst_n = 1'b1;
      wait_drain(40);
      chk("stream_gap_01", hs_cyc[1] - hs_cyc[0], 32'd2);
      chk("stream_gap_12", hs_cyc[2] - hs_cyc[1], 32'd2);
      repeat (3) step();

      // Decode stall for 5 cycles: buffer stable, no new request.
      bus.inst_ready_i = 1'b0;
      mem_k      = 1;
      mem_budget = 2;
      exp_addr_q.push_back(32'h8000_000C);
      exp_addr_q.push_back(32'h8000_0010);
      exp_q.push_back({32'h8000_000C, 32'h7FFF_FFF3});
      exp_q.push_back({32'h8000_0010, 32'h7FFF_FFEF});
      wait_inst_valid(20);
      for (int i = 0; i < 5; i++) begin
         chk("stall_inst", bus.inst_o, 32'h7FFF_FFF3);
         chk("stall_pc", bus.pc_o, 32'h8000_000C);
         chk("stall_no_req", {31'h0, bus.imem_req_valid_o}, 32'h0);
         step();
      end
      bus.inst_ready_i = 1'b1;
      #1;
      chk("drain_req_valid", {31'h0, bus.imem_req_valid_o}, 32'h1);
      chk("drain_req_addr", bus.imem_req_addr_o, 32'h8000_0010);
      wait_drain(40);
      repeat (3) step();

      // Redirect while waiting (k=3): stale word dropped, target aligned.
      mem_k      = 3;
      mem_budget = 2;
      exp_addr_q.push_back(32'h8000_0014);
      exp_addr_q.push_back(32'h8000_0100);
      exp_q.push_back({32'h8000_0100, 32'h7FFF_FEFF});
      wait_state(1'b1, 20);
      bus.redirect_i    = 1'b1;
      bus.redirect_pc_i = 32'h8000_0102;
      step();
      bus.redirect_i = 1'b0;
      chk("redir_wait_state", {31'h0, dbg_state}, 32'h1);
      chk("redir_wait_valid", {31'h0, bus.inst_valid_o}, 32'h0);
      chk("redir_wait_pc", bus.imem_req_addr_o, 32'h8000_0100);
      wait_drain(40);
      repeat (3) step();

      // Redirect in the same cycle as the response (k=2).
      mem_k      = 2;
      mem_budget = 2;
      exp_addr_q.push_back(32'h8000_0104);
      exp_addr_q.push_back(32'h8000_0200);
      exp_q.push_back({32'h8000_0200, 32'h7FFF_FDFF});
      wait_rsp(20);
      bus.redirect_i    = 1'b1;
      bus.redirect_pc_i = 32'h8000_0200;
      step();
      bus.redirect_i = 1'b0;
      chk("redir_rsp_state", {31'h0, dbg_state}, 32'h0);
      chk("redir_rsp_valid", {31'h0, bus.inst_valid_o}, 32'h0);
      chk("redir_rsp_addr", bus.imem_req_addr_o, 32'h8000_0200);
      wait_drain(40);
      repeat (3) step();

      // Redirect in REQ (no handshake) to the top word: low bits ignored, PC wraps.
      bus.redirect_i    = 1'b1;
      bus.redirect_pc_i = 32'hFFFF_FFFF;
      step();
      bus.redirect_i = 1'b0;
      #1;
      chk("wrap_req_addr", bus.imem_req_addr_o, 32'hFFFF_FFFC);
      chk("wrap_req_valid", {31'h0, bus.imem_req_valid_o}, 32'h1);
      mem_k      = 1;
      mem_budget = 2;
      exp_addr_q.push_back(32'hFFFF_FFFC);
      exp_addr_q.push_back(32'h0000_0000);
      exp_q.push_back({32'hFFFF_FFFC, 32'h0000_0003});
      exp_q.push_back({32'h0000_0000, 32'hFFFF_FFFF});
      wait_drain(40);
      repeat (3) step();

      // Buffered word held, then drained into a slow fetch; reset during WAIT.
      bus.inst_ready_i = 1'b0;
      mem_k      = 1;
      mem_budget = 1;
      exp_addr_q.push_back(32'h0000_0004);
      wait_inst_valid(20);
      chk("hold_inst", bus.inst_o, 32'hFFFF_FFFB);
      chk("hold_pc", bus.pc_o, 32'h0000_0004);
      exp_q.push_back({32'h0000_0004, 32'hFFFF_FFFB});
      exp_addr_q.push_back(32'h0000_0008);
      mem_k      = 3;
      mem_budget = 1;
      step();
      bus.inst_ready_i = 1'b1;
      wait_state(1'b1, 20);
      rst_n = 1'b0;
      #1;
      chk("arst_req_valid", {31'h0, bus.imem_req_valid_o}, 32'h0);
      chk("arst_inst_valid", {31'h0, bus.inst_valid_o}, 32'h0);
      chk("arst_inst", bus.inst_o, 32'h0);
      chk("arst_pc_o", bus.pc_o, 32'h0);
      chk("arst_state", {31'h0, dbg_state}, 32'h0);
      chk("arst_req_addr", bus.imem_req_addr_o, 32'h8000_0000);
      mem_k      = 1;
      mem_budget = 1;
      exp_addr_q.push_back(32'h8000_0000);
      exp_q.push_back({32'h8000_0000, 32'h7FFF_FFFF});
      repeat (2) step();
      rst_n = 1'b1;
      wait_drain(40);
      repeat (3) step();

      chk("end_exp_q_empty", exp_q.size(), 32'd0);
      chk("end_addr_q_empty", exp_addr_q.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
